ets_frame_averager: RTL and testbench
=====================================

Name: ets_frame_averager

Overview:
Sits directly downstream of the ETS stream output (axis CDC FIFO master side, M_AXIS clock domain). Consumes tlast-delimited frames of 32-bit ETS hit counts, one word per Vernier phase point, and accumulates them point-wise over 2^N consecutive frames. It then emits one averaged frame on its own AXI-Stream master. Averaging repeated sweeps in hardware cuts DMA bandwidth and software load by 2^N.

Parameters:
DATA_W, 32, width of input and output stream data
MAX_POINTS, 1024, maximum frame length in beats; memory depth
PTR_W, 10, log2(MAX_POINTS)
MAX_AVG_LOG2, 8, largest supported averaging exponent
ACC_W, DATA_W+MAX_AVG_LOG2, accumulator word width (40); no overflow is possible

Ports:
clk  in  1  stream clock; the only clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse; begins a run, ignored while busy
cfg_avg_log2  in  4  averaging exponent N; latched at start; values above MAX_AVG_LOG2 are clamped
busy  out  1  high from the accepted start until done or error abort completes
done  out  1  one-cycle pulse after the last averaged beat is accepted
err_len  out  1  sticky frame-length error; cleared by the next accepted start
frame_len  out  PTR_W+1  beat count of the first frame of the current/last run
s_axis_tdata  in  DATA_W  input count word
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of a sweep frame
m_axis_tdata  out  DATA_W  averaged word
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last beat of the averaged frame

Behaviour:
- Reset values: all outputs 0; state IDLE; idx=0, frame_cnt=0. Reset mid-run aborts immediately; memory contents are don't-care.
- Memory: MAX_POINTS x ACC_W with combinational read (LUTRAM), synchronous write. Read-modify-write of one point completes in a single cycle.
- States:
  - IDLE: s_tready=0. On start, latch N=min(cfg_avg_log2,MAX_AVG_LOG2), clear err_len, set busy, go to FIRST.
  - FIRST: s_tready=1. Each handshake writes mem[idx]=zero-extended tdata and increments idx.
    - tlast: frame_len=idx+1, idx=0, frame_cnt=1. If N==0 go to DRAIN, else go to ACCUM.
    - Beat number MAX_POINTS without tlast: err_len=1, go to FLUSH.
  - ACCUM: s_tready=1. Each handshake writes mem[idx]=mem[idx]+tdata.
    - tlast with idx==frame_len-1: idx=0, frame_cnt++. If frame_cnt+1==2^N go to DRAIN.
    - tlast with idx!=frame_len-1, or idx==frame_len-1 without tlast: err_len=1. If that beat lacked tlast go to FLUSH, else go to IDLE (busy=0).
  - FLUSH: s_tready=1; beats are discarded. On a tlast beat go to IDLE, busy=0, no done pulse.
  - DRAIN: s_tready=0. Single output register, standard AXIS rules:
    - tdata and tlast stay stable while tvalid && !tready.
    - tdata = (mem[idx] >> N) truncated to DATA_W.
    - tlast=1 on idx==frame_len-1.
    - Sustains 1 beat/clk under continuous tready.
    - After the tlast beat handshakes: tvalid=0, done=1 for one cycle, busy=0, go to IDLE.
- Latency: the first output beat is valid on the cycle after entering DRAIN.
- s_tready depends only on state, never combinationally on s_tvalid.
- Input stalls (tvalid=0) and output stalls (tready=0) of any length do not affect results.
- A start pulse in any state other than IDLE is ignored.
- A single-beat frame (frame_len=1) is legal.

Decomposition:
- Shared package ets_pkg: state enum (IDLE, FIRST, ACCUM, FLUSH, DRAIN) and constants MAX_POINTS, MAX_AVG_LOG2, ACC_W.
- One sub-module, ets_acc_ram: simple-dual-port memory with async read and sync write, parameterized by depth and width.
- Control FSM, idx/frame_cnt counters and the output register live in the top module.

Test Plan:
- N=2, 4 frames of 8 beats with data=k*10+frame (k=0..7) -> 8 output beats = k*10+1 (sum k*40+6, >>2); tlast only on beat 8; one done pulse.
- N=0, one 5-beat frame of 0xFFFFFFFF -> output echoes input exactly; no overflow.
- N=8, 256 frames of 3 beats, all 0xFFFFFFFF -> output 0xFFFFFFFF ×3, proving the 40-bit accumulator does not wrap.
- Random m_tready (30% low) and random s_tvalid gaps on the N=2 case -> identical output sequence; tdata held stable during stalls.
- Second frame has tlast at beat 6 with frame_len=8 -> err_len=1, FSM returns to IDLE, no done, no output beats; next start clears err_len.
- First frame of 1030 beats with MAX_POINTS=1024 -> err_len at beat 1024; remaining beats flushed until tlast; start pulsed while busy has no effect.

Source files
------------

// File: rtl/ets_pkg.sv
// Shared types and sizing constants for the ETS frame averager.
package ets_pkg;
    localparam int MAX_POINTS   = 1024;
    localparam int MAX_AVG_LOG2 = 8;
    localparam int ACC_W        = 32 + MAX_AVG_LOG2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FIRST = 3'd1,
        ACCUM = 3'd2,
        FLUSH = 3'd3,
        DRAIN = 3'd4
    } state_e;
endpackage

// File: rtl/ets_acc_ram.sv
// Point-wise accumulator memory: asynchronous read, synchronous write, so a
// read-modify-write of one point fits in a single clock.
module ets_acc_ram
    import ets_pkg::*;
#(
    parameter int DEPTH = MAX_POINTS,
    parameter int WIDTH = ACC_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ets_frame_averager.sv
// Accumulates 2^N tlast-delimited ETS sweep frames point-wise and streams out
// one averaged frame on an AXI-Stream master.
module ets_frame_averager
    import ets_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int MAX_POINTS   = ets_pkg::MAX_POINTS,
    parameter int PTR_W        = 10,
    parameter int MAX_AVG_LOG2 = ets_pkg::MAX_AVG_LOG2,
    parameter int ACC_W        = DATA_W + MAX_AVG_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        cfg_avg_log2,
    output logic              busy,
    output logic              done,
    output logic              err_len,
    output logic [PTR_W:0]    frame_len,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [2:0]        dbg_state
);
    state_e                  state_q;
    logic [PTR_W-1:0]        idx_q;
    logic [MAX_AVG_LOG2:0]   frame_cnt_q;
    logic [3:0]              n_q;
    logic [PTR_W:0]          frame_len_q;
    logic                    busy_q, done_q, err_q;
    logic                    m_valid_q, m_last_q;
    logic [DATA_W-1:0]       m_data_q;

    logic                    s_hs;
    logic                    ram_we;
    logic [ACC_W-1:0]        ram_wdata, ram_rdata, s_data_ext;
    logic [PTR_W-1:0]        last_idx;
    logic                    at_last;
    logic [3:0]              cfg_clamped;
    logic [MAX_AVG_LOG2+1:0] frames_target, cnt_next;
    logic [DATA_W-1:0]       drain_word;

    assign s_axis_tready = (state_q == FIRST) || (state_q == ACCUM) || (state_q == FLUSH);
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign s_data_ext    = {{(ACC_W-DATA_W){1'b0}}, s_axis_tdata};
    assign last_idx      = PTR_W'(frame_len_q - 1'b1);
    assign at_last       = (idx_q == last_idx);
    assign cfg_clamped   = (cfg_avg_log2 > 4'(MAX_AVG_LOG2)) ? 4'(MAX_AVG_LOG2) : cfg_avg_log2;
    assign frames_target = (MAX_AVG_LOG2+2)'(1) << n_q;
    assign cnt_next      = {1'b0, frame_cnt_q} + 1'b1;
    assign drain_word    = DATA_W'(ram_rdata >> n_q);

    // First frame overwrites stale contents; later frames add onto them.
    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = s_data_ext;
        if (s_hs && state_q == FIRST) begin
            ram_we = 1'b1;
        end else if (s_hs && state_q == ACCUM) begin
            ram_we    = 1'b1;
            ram_wdata = ram_rdata + s_data_ext;
        end
    end

    ets_acc_ram #(
        .DEPTH (MAX_POINTS),
        .WIDTH (ACC_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (idx_q),
        .wdata_i (ram_wdata),
        .raddr_i (idx_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            n_q         <= '0;
            frame_len_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q         <= cfg_clamped;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        idx_q       <= '0;
                        frame_cnt_q <= '0;
                        state_q     <= FIRST;
                    end
                end
                FIRST: begin
                    if (s_hs) begin
                        if (s_axis_tlast) begin
                            frame_len_q <= {1'b0, idx_q} + 1'b1;
                            idx_q       <= '0;
                            frame_cnt_q <= 1;
                            state_q     <= (n_q == 4'd0) ? DRAIN : ACCUM;
                        end else if (idx_q == PTR_W'(MAX_POINTS - 1)) begin
                            err_q   <= 1'b1;
                            state_q <= FLUSH;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (s_hs) begin
                        if (s_axis_tlast && at_last) begin
                            idx_q       <= '0;
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                            if (cnt_next == frames_target) begin
                                state_q <= DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            // Frame ended early: the sweep is already finished.
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else if (at_last) begin
                            err_q   <= 1'b1;
                            state_q <= FLUSH;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (s_hs && s_axis_tlast) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    // Output register refills whenever it is empty or being consumed.
                    if (!m_valid_q || m_axis_tready) begin
                        if (m_valid_q && m_last_q) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            m_data_q  <= drain_word;
                            m_last_q  <= at_last;
                            m_valid_q <= 1'b1;
                            idx_q     <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err_len       = err_q;
    assign frame_len     = frame_len_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_ets_frame_averager.sv
// Self-checking bench for ets_frame_averager: table-driven runs against an
// arithmetic reference model plus hand-written error and reset sequences.
module tb_ets_frame_averager;
    localparam int DATA_W = 32;
    localparam int PTR_W  = 10;

    logic              clk = 1'b0;
    logic              reset, start;
    logic [3:0]        cfg_avg_log2;
    logic              busy, done, err_len;
    logic [PTR_W:0]    frame_len;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tlast;
    logic              m_axis_tready = 1'b1;
    logic [2:0]        dbg_state;

    ets_frame_averager dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_avg_log2  (cfg_avg_log2),
        .busy          (busy),
        .done          (done),
        .err_len       (err_len),
        .frame_len     (frame_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    int          done_cnt = 0;
    int          out_cnt  = 0;
    logic [31:0] first_out = '0;
    logic        stall_mode = 1'b0;
    logic        mon_hold = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_last = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Output monitor: handshake happens at the next posedge when valid && ready here.
    always @(negedge clk) begin
        if (reset) begin
            mon_hold = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (mon_hold) begin
                check("hold_tdata", 64'(m_axis_tdata), 64'(held_data));
                check("hold_tlast", 64'(m_axis_tlast), 64'(held_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (out_cnt == 0) first_out = m_axis_tdata;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out_beat", 64'(m_axis_tvalid), 64'd0);
                end else begin
                    check("out_tdata", 64'(m_axis_tdata), 64'(exp_q.pop_front()));
                    check("out_tlast", 64'(m_axis_tlast), 64'(exp_last_q.pop_front()));
                end
            end
            mon_hold  = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
            held_last = m_axis_tlast;
        end
    end

    // Output backpressure: ~30% low in stall mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = stall_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input logic [3:0] cfg);
        cfg_avg_log2 = cfg;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] data, input logic last);
        logic hs;
        int   c;
        if (stall_mode) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        hs = 1'b0;
        c  = 0;
        while (!hs && c < 200) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            c++;
        end
        if (!hs) check("s_tready_timeout", 64'(s_axis_tready), 64'd1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_done_and_check(input int pts);
        int c = 0;
        while (done_cnt == 0 && c < 5000) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("out_beats", 64'(out_cnt), 64'(pts));
        check("exp_left", 64'(exp_q.size()), 64'd0);
        check("busy_end", 64'(busy), 64'd0);
        check("err_len_end", 64'(err_len), 64'd0);
        check("frame_len", 64'(frame_len), 64'(pts));
        check("m_tvalid_end", 64'(m_axis_tvalid), 64'd0);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] pat_word(int pat, int f, int k);
        case (pat)
            0:       return 32'(k * 10 + f);
            1:       return 32'hFFFF_FFFF;
            3:       return 32'(f);
            default: return $urandom();
        endcase
    endfunction

    typedef struct {
        logic [3:0]  cfg;
        int          frames;
        int          pts;
        int          pat;
        bit          stall;
        bit          chk_w0;
        logic [31:0] exp_w0;
    } vec_t;

    task automatic run_vec(input vec_t v, input int id);
        logic [31:0]     words[$];
        int              n_eff;
        longint unsigned sum;
        n_eff = (v.cfg > 4'd8) ? 8 : int'(v.cfg);
        for (int f = 0; f < v.frames; f++)
            for (int k = 0; k < v.pts; k++)
                words.push_back(pat_word(v.pat, f, k));
        // Average of each point over all frames, floor division by 2^N.
        for (int k = 0; k < v.pts; k++) begin
            sum = 0;
            for (int f = 0; f < v.frames; f++) sum += 64'(words[f * v.pts + k]);
            exp_q.push_back(32'(sum / (64'd1 << n_eff)));
            exp_last_q.push_back(k == v.pts - 1);
        end
        done_cnt   = 0;
        out_cnt    = 0;
        stall_mode = v.stall;
        pulse_start(v.cfg);
        check("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < words.size(); i++)
            send_beat(words[i], (i % v.pts) == v.pts - 1);
        wait_done_and_check(v.pts);
        if (v.chk_w0) check($sformatf("vec%0d_first_word", id), 64'(first_out), 64'(v.exp_w0));
        stall_mode = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[6];

    initial begin
        vecs[0] = '{cfg: 4'd2,  frames: 4,   pts: 8,  pat: 0, stall: 1'b0, chk_w0: 1'b1, exp_w0: 32'd1};
        vecs[1] = '{cfg: 4'd0,  frames: 1,   pts: 5,  pat: 1, stall: 1'b0, chk_w0: 1'b1, exp_w0: 32'hFFFF_FFFF};
        vecs[2] = '{cfg: 4'd8,  frames: 256, pts: 3,  pat: 1, stall: 1'b0, chk_w0: 1'b1, exp_w0: 32'hFFFF_FFFF};
        vecs[3] = '{cfg: 4'd2,  frames: 4,   pts: 8,  pat: 0, stall: 1'b1, chk_w0: 1'b1, exp_w0: 32'd1};
        vecs[4] = '{cfg: 4'd15, frames: 256, pts: 1,  pat: 3, stall: 1'b0, chk_w0: 1'b1, exp_w0: 32'd127};
        vecs[5] = '{cfg: 4'd3,  frames: 8,   pts: 16, pat: 2, stall: 1'b1, chk_w0: 1'b0, exp_w0: 32'd0};

        reset         = 1'b1;
        start         = 1'b0;
        cfg_avg_log2  = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err_len", 64'(err_len), 64'd0);
        check("rst_frame_len", 64'(frame_len), 64'd0);
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Early tlast in the second frame: abort to idle with no output.
        done_cnt = 0;
        out_cnt  = 0;
        pulse_start(4'd1);
        for (int k = 0; k < 8; k++) send_beat(32'(k), k == 7);
        for (int k = 0; k < 6; k++) send_beat(32'(k), k == 5);
        repeat (4) @(posedge clk);
        #1;
        check("early_err_len", 64'(err_len), 64'd1);
        check("early_busy", 64'(busy), 64'd0);
        check("early_s_tready", 64'(s_axis_tready), 64'd0);
        check("early_done", 64'(done_cnt), 64'd0);
        check("early_out", 64'(out_cnt), 64'd0);
        pulse_start(4'd0);
        check("restart_clears_err", 64'(err_len), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        exp_q.push_back(32'h11);
        exp_last_q.push_back(1'b0);
        exp_q.push_back(32'h22);
        exp_last_q.push_back(1'b1);
        send_beat(32'h11, 1'b0);
        send_beat(32'h22, 1'b1);
        wait_done_and_check(2);

        // Missing tlast at end of an accumulate frame: flush until tlast.
        done_cnt = 0;
        out_cnt  = 0;
        pulse_start(4'd1);
        for (int k = 0; k < 4; k++) send_beat(32'(k), k == 3);
        for (int k = 0; k < 4; k++) send_beat(32'(k), 1'b0);
        check("late_err_len", 64'(err_len), 64'd1);
        check("late_busy_flush", 64'(busy), 64'd1);
        send_beat(32'd9, 1'b0);
        send_beat(32'd9, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("late_busy_end", 64'(busy), 64'd0);
        check("late_done", 64'(done_cnt), 64'd0);
        check("late_out", 64'(out_cnt), 64'd0);

        // Overlong first frame: error at beat MAX_POINTS, then flush.
        done_cnt = 0;
        out_cnt  = 0;
        pulse_start(4'd0);
        for (int i = 0; i < 1023; i++) send_beat(32'(i), 1'b0);
        check("long_no_err_yet", 64'(err_len), 64'd0);
        send_beat(32'd1023, 1'b0);
        check("long_err_len", 64'(err_len), 64'd1);
        check("long_busy", 64'(busy), 64'd1);
        pulse_start(4'd2);
        check("busy_start_ignored_err", 64'(err_len), 64'd1);
        check("busy_start_ignored_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 6; i++) send_beat(32'(i), i == 5);
        repeat (2) @(posedge clk);
        #1;
        check("long_busy_end", 64'(busy), 64'd0);
        check("long_err_sticky", 64'(err_len), 64'd1);
        check("long_done", 64'(done_cnt), 64'd0);
        check("long_out", 64'(out_cnt), 64'd0);
        check("long_s_tready", 64'(s_axis_tready), 64'd0);

        // Reset in the middle of a run aborts it.
        pulse_start(4'd2);
        for (int k = 0; k < 3; k++) send_beat(32'(k), 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_s_tready", 64'(s_axis_tready), 64'd0);
        check("midrst_err", 64'(err_len), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
